// File: rtl/convert_32_8.sv
// Purpose: width-down converter, one 32-bit word in, four bytes out (order set by BIG_ENDIAN).
// Latency: a word accepted in cycle N presents byte 0 in cycle N+1, then one byte per accepted cycle.
// Backpressure: i_trdy low freezes the presented byte; o_rrdy only rises on the last byte's handshake.
module convert_32_8 #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_data,
  input  logic        i_rval,
  output logic        o_rrdy,
  output logic [7:0]  o_data,
  output logic        o_tval,
  input  logic        i_trdy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;

  logic        i_xfer;
  logic        o_xfer;
  logic        last_byte;
  logic [1:0]  byte_sel;

  // Handshake terms; o_rrdy depends only on state and i_trdy, never on i_rval.
  assign last_byte = (cnt_q == 2'd3);
  assign o_tval    = (state_q == TX);
  assign o_rrdy    = (state_q == IDLE) | ((state_q == TX) & last_byte & i_trdy);
  assign i_xfer    = i_rval & o_rrdy;
  assign o_xfer    = o_tval & i_trdy;

  // Next-state logic: load on accept, advance on each byte taken, reload on the last byte for back-to-back words.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (i_xfer) begin
          data_d  = i_data;
          cnt_d   = 2'd0;
          state_d = TX;
        end
      end
      TX: begin
        if (o_xfer) begin
          if (!last_byte) begin
            cnt_d = cnt_q + 2'd1;
          end else if (i_xfer) begin
            data_d = i_data;
            cnt_d  = 2'd0;
          end else begin
            cnt_d   = 2'd0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // State registers; reset discards any partially sent word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Byte lane select from the held word; big-endian walks the lanes from the top down.
  always_comb begin
    byte_sel = BIG_ENDIAN ? ~cnt_q : cnt_q;
    case (byte_sel)
      2'd0:    o_data = data_q[7:0];
      2'd1:    o_data = data_q[15:8];
      2'd2:    o_data = data_q[23:16];
      default: o_data = data_q[31:24];
    endcase
  end

endmodule

// File: tb/tb_convert_32_8.sv
// Bench for convert_32_8: little- and big-endian instances share stimulus.
// Each accepted word pushes its expected byte order into a per-instance queue.
// Directed sequences check handshake timing; a random phase stresses the scoreboard.
module tb_convert_32_8;

  logic        clk;
  logic        reset_n;
  logic [31:0] i_data;
  logic        i_rval;
  logic        i_trdy;
  logic        rrdy_le, rrdy_be;
  logic        tval_le, tval_be;
  logic [7:0]  data_le, data_be;

  int total = 0;
  int bad   = 0;

  logic [7:0] q_le[$];
  logic [7:0] q_be[$];

  convert_32_8 #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_rval(i_rval),
    .o_rrdy(rrdy_le), .o_data(data_le), .o_tval(tval_le), .i_trdy(i_trdy)
  );

  convert_32_8 #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_rval(i_rval),
    .o_rrdy(rrdy_be), .o_data(data_be), .o_tval(tval_be), .i_trdy(i_trdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_hs(input string tag, input logic tv, input logic rr);
    check({tag, "_tval_le"}, tval_le, tv);
    check({tag, "_rrdy_le"}, rrdy_le, rr);
    check({tag, "_tval_be"}, tval_be, tv);
    check({tag, "_rrdy_be"}, rrdy_be, rr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: compare each byte handshake, then record each accepted word.
  always @(negedge clk) begin
    if (reset_n) begin
      if (tval_le && i_trdy) begin
        check("le_q_nonempty", 32'(q_le.size() != 0), 32'd1);
        if (q_le.size() != 0) check("le_byte", data_le, q_le.pop_front());
      end
      if (tval_be && i_trdy) begin
        check("be_q_nonempty", 32'(q_be.size() != 0), 32'd1);
        if (q_be.size() != 0) check("be_byte", data_be, q_be.pop_front());
      end
      if (i_rval && rrdy_le) begin
        q_le.push_back(i_data[7:0]);
        q_le.push_back(i_data[15:8]);
        q_le.push_back(i_data[23:16]);
        q_le.push_back(i_data[31:24]);
      end
      if (i_rval && rrdy_be) begin
        q_be.push_back(i_data[31:24]);
        q_be.push_back(i_data[23:16]);
        q_be.push_back(i_data[15:8]);
        q_be.push_back(i_data[7:0]);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    i_data  = 32'd0;
    i_rval  = 1'b0;
    i_trdy  = 1'b0;
    mid();
    chk_hs("rst", 1'b0, 1'b1);
    check("rst_data_le", data_le, 8'h00);
    check("rst_data_be", data_be, 8'h00);
    tick();
    reset_n = 1'b1;

    // Single word, no backpressure.
    tick(); i_rval = 1'b1; i_data = 32'h44332211; i_trdy = 1'b1;
    mid(); chk_hs("sw0", 1'b0, 1'b1);
    tick(); i_rval = 1'b0;
    mid(); chk_hs("sw1", 1'b1, 1'b0);
    check("sw1_le", data_le, 8'h11);
    check("sw1_be", data_be, 8'h44);
    tick(); mid(); chk_hs("sw2", 1'b1, 1'b0);
    tick(); mid(); chk_hs("sw3", 1'b1, 1'b0);
    tick(); mid(); chk_hs("sw4", 1'b1, 1'b1);
    check("sw4_le", data_le, 8'h44);
    check("sw4_be", data_be, 8'h11);
    tick(); mid(); chk_hs("sw5", 1'b0, 1'b1);

    // Backpressure on byte 1 and on the last byte.
    tick(); i_rval = 1'b1; i_data = 32'hA1B2C3D4;
    mid();
    tick(); i_rval = 1'b0;
    mid(); chk_hs("bp_b0", 1'b1, 1'b0);
    check("bp_b0_le", data_le, 8'hD4);
    for (int i = 0; i < 3; i++) begin
      tick(); i_trdy = 1'b0;
      mid(); chk_hs("bp_hold", 1'b1, 1'b0);
      check("bp_hold_le", data_le, 8'hC3);
      check("bp_hold_be", data_be, 8'hB2);
    end
    tick(); i_trdy = 1'b1;
    mid(); chk_hs("bp_b1", 1'b1, 1'b0);
    check("bp_b1_le", data_le, 8'hC3);
    tick(); mid(); chk_hs("bp_b2", 1'b1, 1'b0);
    tick(); i_trdy = 1'b0;
    mid(); chk_hs("bp_b3_stall", 1'b1, 1'b0);
    check("bp_b3_le", data_le, 8'hA1);
    tick(); i_trdy = 1'b1;
    mid(); chk_hs("bp_b3_take", 1'b1, 1'b1);
    tick(); mid(); chk_hs("bp_idle", 1'b0, 1'b1);

    // Back-to-back words with continuous valid.
    tick(); i_rval = 1'b1; i_data = 32'h03020100;
    mid(); chk_hs("bb0", 1'b0, 1'b1);
    tick(); i_data = 32'h07060504;
    mid(); chk_hs("bb1", 1'b1, 1'b0);
    tick(); mid(); chk_hs("bb2", 1'b1, 1'b0);
    tick(); mid(); chk_hs("bb3", 1'b1, 1'b0);
    tick(); mid(); chk_hs("bb4", 1'b1, 1'b1);
    check("bb4_le", data_le, 8'h03);
    tick(); i_rval = 1'b0;
    mid(); chk_hs("bb5", 1'b1, 1'b0);
    check("bb5_le", data_le, 8'h04);
    check("bb5_be", data_be, 8'h07);
    tick(); mid(); chk_hs("bb6", 1'b1, 1'b0);
    tick(); mid(); chk_hs("bb7", 1'b1, 1'b0);
    tick(); mid(); chk_hs("bb8", 1'b1, 1'b1);
    check("bb8_le", data_le, 8'h07);
    tick(); mid(); chk_hs("bb9", 1'b0, 1'b1);

    // Valid with changing data while not ready must be ignored.
    tick(); i_rval = 1'b1; i_data = 32'h55667788;
    mid();
    for (int i = 0; i < 3; i++) begin
      tick(); i_data = $urandom;
      mid(); chk_hs("ign", 1'b1, 1'b0);
    end
    tick(); i_rval = 1'b0;
    mid(); chk_hs("ign_last", 1'b1, 1'b1);
    check("ign_last_le", data_le, 8'h55);
    check("ign_last_be", data_be, 8'h88);
    tick(); mid(); chk_hs("ign_idle", 1'b0, 1'b1);

    // Reset in the middle of a word.
    tick(); i_rval = 1'b1; i_data = 32'h44332211;
    mid();
    tick(); i_rval = 1'b0;
    mid();
    tick(); mid();
    check("mr_b1_le", data_le, 8'h22);
    tick(); reset_n = 1'b0;
    #1;
    chk_hs("mr_async", 1'b0, 1'b1);
    check("mr_data_le", data_le, 8'h00);
    check("mr_data_be", data_be, 8'h00);
    q_le.delete();
    q_be.delete();
    mid();
    tick(); reset_n = 1'b1;
    mid(); chk_hs("mr_rel", 1'b0, 1'b1);
    tick(); mid(); chk_hs("mr_rel2", 1'b0, 1'b1);
    tick(); i_rval = 1'b1; i_data = 32'h000000EE;
    mid();
    tick(); i_rval = 1'b0;
    mid(); chk_hs("mr_new", 1'b1, 1'b0);
    check("mr_new_le", data_le, 8'hEE);
    check("mr_new_be", data_be, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(); mid();
    end
    tick(); mid(); chk_hs("mr_idle", 1'b0, 1'b1);

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      tick();
      i_rval = 1'($urandom_range(0, 1));
      i_data = $urandom;
      i_trdy = ($urandom_range(0, 3) != 0);
    end
    tick(); i_rval = 1'b0; i_trdy = 1'b1;
    for (int i = 0; i < 20 && (tval_le || tval_be); i++) begin
      tick();
    end
    mid();
    chk_hs("drain", 1'b0, 1'b1);
    check("drain_q_le", q_le.size(), 32'd0);
    check("drain_q_be", q_be.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
